// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: sequences MEM-stage loads and stores against a data
// memory with variable latency. It runs a req/ack handshake, stalls the
// pipeline while an access is outstanding, and captures load data.
// Optional build macro DMEM_TIMEOUT_EN adds a BUSY watchdog. The watchdog
// aborts an access that gets no ack and sets the sticky Timeout_Err flag.
//
// state | meaning
// IDLE  | evaluate the MEM-stage op; a memory op raises the stall and moves on
// BUSY  | request held on the memory port until ack (or watchdog expiry)
// DONE  | stall released; the pipeline advances at the end of this cycle
module dmem_access_ctrl #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Mem_Read_M,
  input  logic        Mem_Write_M,
  input  logic [31:0] ALU_Result_M,
  input  logic [31:0] Write_Data_M,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic [31:0] Read_Data_M,
  output logic        Stall_M,
  output logic        Bubble_W,
  output logic        Timeout_Err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  logic   access;
  logic   is_load;

  // A simultaneous read and write is handled as a write, so it never captures data.
  assign access  = Mem_Read_M | Mem_Write_M;
  assign is_load = Mem_Read_M & ~Mem_Write_M;

`ifdef DMEM_TIMEOUT_EN
  logic [7:0] to_cnt;
  logic       to_hit;

  assign to_hit = (to_cnt == 8'(TIMEOUT_CYCLES - 1));

  // Watchdog: counts BUSY cycles without ack, cleared at the start of each access.
  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt <= 8'd0;
    end else if (state == IDLE && access) begin
      to_cnt <= 8'd0;
    end else if (state == BUSY && !dmem_ack && !to_hit) begin
      to_cnt <= to_cnt + 8'd1;
    end
  end

  // Sticky abort flag; only reset clears it. A final-cycle ack takes priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      Timeout_Err <= 1'b0;
    end else if (state == BUSY && !dmem_ack && to_hit) begin
      Timeout_Err <= 1'b1;
    end
  end
`else
  assign Timeout_Err = 1'b0;
`endif

  // Main sequencer; load data is captured on the edge that accepts the ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      Read_Data_M <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (access) state <= BUSY;
        end
        BUSY: begin
          if (dmem_ack) begin
            state <= DONE;
            if (is_load) Read_Data_M <= dmem_rdata;
          end
`ifdef DMEM_TIMEOUT_EN
          else if (to_hit) begin
            state       <= DONE;
            Read_Data_M <= 32'h0;
          end
`endif
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Memory port is driven straight from EX/MEM; it stays stable because the stall holds EX/MEM.
  assign dmem_req   = (state == BUSY);
  assign dmem_we    = (state == BUSY) & Mem_Write_M;
  assign dmem_addr  = ALU_Result_M;
  assign dmem_wdata = Write_Data_M;

  // The stall rises in the same IDLE cycle that sees the op. This keeps EX/MEM from advancing early.
  assign Stall_M  = (state == BUSY) | ((state == IDLE) & access);
  assign Bubble_W = Stall_M;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: directed steps followed by randomized ops.
// The expected results come from a per-instruction timeline model.
module tb_dmem_access_ctrl;

  logic        clk;
  logic        rst;
  logic        Mem_Read_M;
  logic        Mem_Write_M;
  logic [31:0] ALU_Result_M;
  logic [31:0] Write_Data_M;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;
  logic [31:0] Read_Data_M;
  logic        Stall_M;
  logic        Bubble_W;
  logic        Timeout_Err;

  int tests = 0;
  int fails = 0;

  logic [31:0] exp_rd;
  logic        exp_terr;

`ifdef DMEM_TIMEOUT_EN
  localparam int TO_LIMIT = 16;
`else
  localparam int TO_LIMIT = 1 << 30;
`endif

  dmem_access_ctrl #(.TIMEOUT_CYCLES(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .Mem_Read_M   (Mem_Read_M),
    .Mem_Write_M  (Mem_Write_M),
    .ALU_Result_M (ALU_Result_M),
    .Write_Data_M (Write_Data_M),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_addr    (dmem_addr),
    .dmem_wdata   (dmem_wdata),
    .dmem_rdata   (dmem_rdata),
    .dmem_ack     (dmem_ack),
    .Read_Data_M  (Read_Data_M),
    .Stall_M      (Stall_M),
    .Bubble_W     (Bubble_W),
    .Timeout_Err  (Timeout_Err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // An instruction occupies MEM for these cycles:
  // - a non-memory op takes one cycle with no stall;
  // - a memory op takes one IDLE cycle with the stall raised;
  // - then min(d+1, limit) request cycles, with ack in request cycle d;
  // - then one released cycle.
  task automatic run_op(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input int d, input logic [31:0] rdata);
    int busy_n;
    bit timed_out;
    timed_out = (d + 1 > TO_LIMIT);
    busy_n    = timed_out ? TO_LIMIT : d + 1;
    Mem_Read_M   = rd;
    Mem_Write_M  = wr;
    ALU_Result_M = addr;
    Write_Data_M = wdata;
    dmem_ack     = 1'($urandom_range(0, 1));
    dmem_rdata   = $urandom;
    @(negedge clk);
    if (!(rd | wr)) begin
      check("alu_stall", Stall_M, 0);
      check("alu_bubble", Bubble_W, 0);
      check("alu_req", dmem_req, 0);
      check("alu_rdata_hold", Read_Data_M, exp_rd);
      next_cycle();
      return;
    end
    check("idle_stall", Stall_M, 1);
    check("idle_bubble", Bubble_W, 1);
    check("idle_req", dmem_req, 0);
    for (int i = 0; i < busy_n; i++) begin
      next_cycle();
      dmem_ack   = (i == d);
      dmem_rdata = (i == d) ? rdata : $urandom;
      @(negedge clk);
      check("busy_req", dmem_req, 1);
      check("busy_we", dmem_we, wr);
      check("busy_addr", dmem_addr, addr);
      if (wr) check("busy_wdata", dmem_wdata, wdata);
      check("busy_stall", Stall_M, 1);
      check("busy_bubble", Bubble_W, 1);
      check("busy_rdata_hold", Read_Data_M, exp_rd);
    end
    if (timed_out) begin
      exp_rd   = 32'h0;
      exp_terr = 1'b1;
    end else if (rd && !wr) begin
      exp_rd = rdata;
    end
    next_cycle();
    dmem_ack   = 1'($urandom_range(0, 1));
    dmem_rdata = $urandom;
    @(negedge clk);
    check("done_stall", Stall_M, 0);
    check("done_bubble", Bubble_W, 0);
    check("done_req", dmem_req, 0);
    check("done_rdata", Read_Data_M, exp_rd);
    check("done_terr", Timeout_Err, exp_terr);
    next_cycle();
  endtask

  initial begin
    rst = 1'b1;
    Mem_Read_M = 1'b0;
    Mem_Write_M = 1'b0;
    ALU_Result_M = 32'h0;
    Write_Data_M = 32'h0;
    dmem_rdata = 32'h0;
    dmem_ack = 1'b0;
    exp_rd = 32'h0;
    exp_terr = 1'b0;
    #1;
    next_cycle();
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    check("reset_req", dmem_req, 0);
    check("reset_stall", Stall_M, 0);
    check("reset_rdata", Read_Data_M, 0);
    check("reset_terr", Timeout_Err, 0);
    next_cycle();

    // load with ack in its first request cycle
    run_op(1'b1, 1'b0, 32'h40, 32'h0, 0, 32'hCAFE0001);
    // store acked in its fifth request cycle
    run_op(1'b0, 1'b1, 32'h44, 32'h12345678, 4, 32'h0BAD0BAD);
    // back-to-back load then store
    run_op(1'b1, 1'b0, 32'h48, 32'h0, 0, 32'h5A5A1234);
    run_op(1'b0, 1'b1, 32'h4C, 32'h87654321, 0, 32'h0);
    // ALU ops (random stray ack) and read+write treated as a store
    for (int k = 0; k < 4; k++) run_op(1'b0, 1'b0, $urandom, $urandom, 0, $urandom);
    run_op(1'b1, 1'b1, 32'h50, 32'hA5A5A5A5, 2, 32'hFFFF0000);

    // reset in the middle of an access, while an ack is pending
    Mem_Read_M = 1'b1;
    Mem_Write_M = 1'b0;
    ALU_Result_M = 32'h80;
    dmem_ack = 1'b0;
    next_cycle();
    rst = 1'b1;
    dmem_ack = 1'b1;
    dmem_rdata = 32'hDEADBEEF;
    next_cycle();
    dmem_ack = 1'b0;
    next_cycle();
    rst = 1'b0;
    Mem_Read_M = 1'b0;
    @(negedge clk);
    exp_rd = 32'h0;
    exp_terr = 1'b0;
    check("midrst_req", dmem_req, 0);
    check("midrst_stall", Stall_M, 0);
    check("midrst_rdata", Read_Data_M, 0);
    check("midrst_terr", Timeout_Err, 0);
    next_cycle();

    for (int k = 0; k < 40; k++) begin
      int kind;
      kind = $urandom_range(0, 3);
      run_op(kind[0], kind[1], $urandom, $urandom, $urandom_range(0, 6), $urandom);
    end

`ifdef DMEM_TIMEOUT_EN
    // an ack on the last allowed cycle completes normally
    run_op(1'b1, 1'b0, 32'h60, 32'h0, 15, 32'h11112222);
    // no ack at all: abort after 16 request cycles
    run_op(1'b1, 1'b0, 32'h64, 32'h0, 100, 32'h0);
    for (int k = 0; k < 3; k++) run_op(1'b1, 1'b0, $urandom, 32'h0, 1, $urandom);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
